// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the PC sequencer.
package pc_pkg;

    localparam int unsigned PC_WIDTH        = 16;
    localparam int unsigned PC_STEP         = 2;
    localparam int unsigned PC_RAS_DEPTH    = 4;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data_c,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // wr_ptr points at the next free slot; the top lives one below it.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            overflow_d      = full_q;
            if (!full_q) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty_q) begin
                underflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q - PTR_W'(1);
                count_d  = count_q - CNT_W'(1);
            end
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry contents are left stale across reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top_data_c = mem_q[wr_ptr_q - PTR_W'(1)];
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC select with wrap detection and a return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter int unsigned      STEP         = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int unsigned      RAS_DEPTH    = PC_RAS_DEPTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [WIDTH-1:0] Offset,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] Target,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus,
    output logic             Wrap,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasError
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(STEP - 1);
    localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   br_sum;
    pc_sel_e          sel;
    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top_c;
    logic             ras_full, ras_empty, ras_overflow, ras_underflow;

    assign inc_sum = {1'b0, pc_q} + STEP_EXT;
    assign br_sum  = {1'b0, pc_q} + {1'b0, Offset};

    // Fixed priority; a Ret on an empty stack degrades to a plain increment.
    always_comb begin
        sel = SEL_INC;
        if (Stall) begin
            sel = SEL_HOLD;
        end else if (Ret) begin
            sel = ras_empty ? SEL_INC : SEL_RET;
        end else if (Call) begin
            sel = SEL_CALL;
        end else if (Jump) begin
            sel = SEL_JMP;
        end else if (Branch) begin
            sel = SEL_BR;
        end
    end

    // For a negative offset the unsigned sum carries exactly when no borrow occurs.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = wrap_q;
        case (sel)
            SEL_HOLD: ;
            SEL_INC: begin
                pc_d   = inc_sum[WIDTH-1:0];
                wrap_d = inc_sum[WIDTH];
            end
            SEL_BR: begin
                pc_d   = br_sum[WIDTH-1:0];
                wrap_d = Offset[WIDTH-1] ? ~br_sum[WIDTH] : br_sum[WIDTH];
            end
            SEL_JMP, SEL_CALL: begin
                pc_d   = Target & ALIGN_MASK;
                wrap_d = 1'b0;
            end
            SEL_RET: begin
                pc_d   = ras_top_c;
                wrap_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign ras_push = !Stall && !Ret && Call;
    assign ras_pop  = !Stall && Ret;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q   <= RESET_VECTOR;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (Clock),
        .rst        (Reset),
        .push       (ras_push),
        .pop        (ras_pop),
        .push_data  (inc_sum[WIDTH-1:0]),
        .top_data_c (ras_top_c),
        .full       (ras_full),
        .empty      (ras_empty),
        .overflow   (ras_overflow),
        .underflow  (ras_underflow)
    );

    assign PC       = pc_q;
    assign PCPlus   = inc_sum[WIDTH-1:0];
    assign Wrap     = wrap_q;
    assign RasEmpty = ras_empty;
    assign RasFull  = ras_full;
    assign RasError = ras_overflow | ras_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (WIDTH=16, STEP=2, RAS_DEPTH=4).
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic [15:0] Offset = '0;
    logic        Jump = 1'b0;
    logic        Call = 1'b0;
    logic        Ret = 1'b0;
    logic [15:0] Target = '0;
    logic [15:0] PC;
    logic [15:0] PCPlus;
    logic        Wrap;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasError;

    // Control word order: {Reset, Stall, Ret, Call, Jump, Branch}
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_RST   = 6'b100000;
    localparam logic [5:0] C_STALL = 6'b010000;
    localparam logic [5:0] C_RET   = 6'b001000;
    localparam logic [5:0] C_CALL  = 6'b000100;
    localparam logic [5:0] C_JMP   = 6'b000010;
    localparam logic [5:0] C_BR    = 6'b000001;

    typedef struct {
        int unsigned due;
        logic [15:0] pc;
        logic        wrap;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    pc_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Stall    (Stall),
        .Branch   (Branch),
        .Offset   (Offset),
        .Jump     (Jump),
        .Call     (Call),
        .Ret      (Ret),
        .Target   (Target),
        .PC       (PC),
        .PCPlus   (PCPlus),
        .Wrap     (Wrap),
        .RasEmpty (RasEmpty),
        .RasFull  (RasFull),
        .RasError (RasError)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned at, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, at, act, exp);
        end
    endtask

    // Monitor: compares every entry that falls due at this cycle's sampling point.
    always @(negedge Clock) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL stale_entry due=%0d now=%0d", e.due, cyc);
            end else begin
                chk("pc",     e.due, PC,              e.pc);
                chk("pcplus", e.due, PCPlus,          e.pc + 16'd2);
                chk("wrap",   e.due, 16'(Wrap),       16'(e.wrap));
                chk("empty",  e.due, 16'(RasEmpty),   16'(e.empty));
                chk("full",   e.due, 16'(RasFull),    16'(e.full));
                chk("error",  e.due, 16'(RasError),   16'(e.err));
            end
        end
    end

    task automatic step(input logic [5:0] ctl, input logic [15:0] off, input logic [15:0] tgt,
                        input logic [15:0] pc, input logic w, input logic e, input logic f, input logic er);
        exp_t x;
        @(posedge Clock);
        #1;
        {Reset, Stall, Ret, Call, Jump, Branch} = ctl;
        Offset = off;
        Target = tgt;
        x.due   = cyc + 1;
        x.pc    = pc;
        x.wrap  = w;
        x.empty = e;
        x.full  = f;
        x.err   = er;
        sb.push_back(x);
    endtask

    initial begin
        //    ctl        off       tgt       pc        w     e     f     err
        step(C_RST,   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b0);
        // Jump alignment, then increment wrap held through a stall
        step(C_JMP,   16'h0000, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(C_STALL, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        // Branches: borrow, carry, plain
        step(C_BR,    16'hFFFC, 16'h0000, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0);
        step(C_BR,    16'h0004, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0);
        step(C_BR,    16'h000E, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
        // Call / return pair
        step(C_CALL,  16'h0000, 16'h0101, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0);
        // Five calls, the fifth overflows and drops 0014
        step(C_CALL,  16'h0000, 16'h0200, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h0300, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h0400, 16'h0400, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h0500, 16'h0500, 1'b0, 1'b0, 1'b1, 1'b0);
        step(C_CALL,  16'h0000, 16'h0600, 16'h0600, 1'b0, 1'b0, 1'b1, 1'b1);
        // All requests with stall, then without: only Ret wins
        step(6'b011111, 16'h0010, 16'h0700, 16'h0600, 1'b0, 1'b0, 1'b1, 1'b0);
        step(6'b001111, 16'h0010, 16'h0700, 16'h0502, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0402, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0302, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0202, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0204, 1'b0, 1'b1, 1'b0, 1'b1);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0206, 1'b0, 1'b1, 1'b0, 1'b0);
        // Fill the stack, then reset together with stall
        step(C_CALL,  16'h0000, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h2000, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h3000, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(C_CALL,  16'h0000, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(6'b110000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        step(C_RET,   16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);
        step(C_IDLE,  16'h0000, 16'h0000, 16'h0006, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (4) @(posedge Clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
